// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master round-robin Wishbone classic arbiter with bus watchdog
module wb_arbiter #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] TMO_DATA = 32'hDEADBEEF
) (
  input  logic        io_wbs_clk,
  input  logic        io_wbs_rst_n,
  input  logic [31:0] io_wbs_adr_m0,
  input  logic [31:0] io_wbs_datwr_m0,
  output logic [31:0] io_wbs_datrd_m0,
  input  logic        io_wbs_we_m0,
  input  logic        io_wbs_stb_m0,
  output logic        io_wbs_ack_m0,
  input  logic        io_wbs_cyc_m0,
  input  logic [31:0] io_wbs_adr_m1,
  input  logic [31:0] io_wbs_datwr_m1,
  output logic [31:0] io_wbs_datrd_m1,
  input  logic        io_wbs_we_m1,
  input  logic        io_wbs_stb_m1,
  output logic        io_wbs_ack_m1,
  input  logic        io_wbs_cyc_m1,
  output logic [31:0] io_wbs_adr_s,
  output logic [31:0] io_wbs_datwr_s,
  output logic        io_wbs_we_s,
  output logic        io_wbs_stb_s,
  output logic        io_wbs_cyc_s,
  input  logic [31:0] io_wbs_datrd_s,
  input  logic        io_wbs_ack_s,
  output logic [1:0]  gnt_o,
  output logic        timeout_o
);

  localparam int unsigned WDW = (TIMEOUT != 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = (TIMEOUT != 0) ? WDW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, TMO} state_t;

  state_t         state, state_nxt;
  logic           last_gnt, last_gnt_nxt;
  logic [WDW-1:0] wdog, wdog_nxt;
  logic           req0, req1, own_cyc, own_stb, stalled, wdog_hit;

  assign req0     = io_wbs_cyc_m0 & io_wbs_stb_m0;
  assign req1     = io_wbs_cyc_m1 & io_wbs_stb_m1;
  assign own_cyc  = (state == GNT1) ? io_wbs_cyc_m1 : io_wbs_cyc_m0;
  assign own_stb  = (state == GNT1) ? io_wbs_stb_m1 : io_wbs_stb_m0;
  assign stalled  = own_stb & ~io_wbs_ack_s;
  // A late ack in the final watchdog cycle still completes normally.
  assign wdog_hit = (TIMEOUT != 0) && (wdog == WDOG_LAST) && stalled;

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    wdog_nxt     = '0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_gnt)) begin
          state_nxt    = GNT0;
          last_gnt_nxt = 1'b0;
        end else if (req1) begin
          state_nxt    = GNT1;
          last_gnt_nxt = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (!own_cyc) begin
          // Hand straight over to a waiting master without an idle bubble.
          if (state == GNT0 && req1) begin
            state_nxt    = GNT1;
            last_gnt_nxt = 1'b1;
          end else if (state == GNT1 && req0) begin
            state_nxt    = GNT0;
            last_gnt_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (wdog_hit) begin
          state_nxt = TMO;
        end else if ((TIMEOUT != 0) && stalled) begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wdog     <= '0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      wdog     <= wdog_nxt;
    end
  end

  always_comb begin
    io_wbs_adr_s    = '0;
    io_wbs_datwr_s  = '0;
    io_wbs_we_s     = 1'b0;
    io_wbs_stb_s    = 1'b0;
    io_wbs_cyc_s    = 1'b0;
    io_wbs_ack_m0   = 1'b0;
    io_wbs_ack_m1   = 1'b0;
    io_wbs_datrd_m0 = '0;
    io_wbs_datrd_m1 = '0;
    gnt_o           = 2'b00;
    timeout_o       = 1'b0;
    case (state)
      GNT0: begin
        io_wbs_adr_s    = io_wbs_adr_m0;
        io_wbs_datwr_s  = io_wbs_datwr_m0;
        io_wbs_we_s     = io_wbs_we_m0;
        io_wbs_stb_s    = io_wbs_stb_m0;
        io_wbs_cyc_s    = io_wbs_cyc_m0;
        io_wbs_ack_m0   = io_wbs_ack_s;
        io_wbs_datrd_m0 = io_wbs_datrd_s;
        gnt_o           = 2'b01;
      end
      GNT1: begin
        io_wbs_adr_s    = io_wbs_adr_m1;
        io_wbs_datwr_s  = io_wbs_datwr_m1;
        io_wbs_we_s     = io_wbs_we_m1;
        io_wbs_stb_s    = io_wbs_stb_m1;
        io_wbs_cyc_s    = io_wbs_cyc_m1;
        io_wbs_ack_m1   = io_wbs_ack_s;
        io_wbs_datrd_m1 = io_wbs_datrd_s;
        gnt_o           = 2'b10;
      end
      TMO: begin
        // last_gnt still names the master whose access is being aborted.
        timeout_o = 1'b1;
        if (last_gnt) begin
          io_wbs_ack_m1   = 1'b1;
          io_wbs_datrd_m1 = TMO_DATA;
          gnt_o           = 2'b10;
        end else begin
          io_wbs_ack_m0   = 1'b1;
          io_wbs_datrd_m0 = TMO_DATA;
          gnt_o           = 2'b01;
        end
      end
      default: ;
    endcase
  end

endmodule
